// File: rtl/pcounter_stack.sv
// Program counter with a hardware return-address stack.
// Ports: clk, rst (async, active-high); command strobes enable/jump/branch/call/ret
// in fixed priority ret > call > jump > branch > enable; out_enable gates pc
// onto bus_out; bus_in carries target or signed offset; pc, depth,
// stack_empty, stack_full and sticky fault report registered state.
module pcounter_stack #(
    parameter int                         ADDRESS_WIDTH = 4,
    parameter int                         STACK_DEPTH   = 4,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_VECTOR  = '0,
    localparam int                        DW = $clog2(STACK_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     jump,
    input  logic                     branch,
    input  logic                     call,
    input  logic                     ret,
    input  logic                     out_enable,
    input  logic [ADDRESS_WIDTH-1:0] bus_in,
    output logic [ADDRESS_WIDTH-1:0] bus_out,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic [DW-1:0]            depth,
    output logic                     stack_empty,
    output logic                     stack_full,
    output logic                     fault
);

    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DW-1:0] FULL_DEPTH = DW'(STACK_DEPTH);
    localparam logic [DW-1:0] ONE_DEPTH  = DW'(1);

    logic [ADDRESS_WIDTH-1:0] stack_mem [STACK_DEPTH];

    logic [ADDRESS_WIDTH-1:0] pc_inc;
    logic [ADDRESS_WIDTH-1:0] pc_next;
    logic [DW-1:0]            depth_next;
    logic [DW-1:0]            depth_m1;
    logic [IW-1:0]            push_idx;
    logic [IW-1:0]            pop_idx;
    logic                     fault_next;
    logic                     push;

    assign pc_inc   = pc + 1'b1;
    assign depth_m1 = depth - ONE_DEPTH;
    assign push_idx = depth[IW-1:0];
    assign pop_idx  = depth_m1[IW-1:0];

    assign stack_empty = (depth == '0);
    assign stack_full  = (depth == FULL_DEPTH);
    assign bus_out     = out_enable ? pc : '0;

    // Only the highest-priority strobe acts; the rest are ignored.
    always_comb begin
        pc_next    = pc;
        depth_next = depth;
        fault_next = fault;
        push       = 1'b0;
        if (ret) begin
            if (stack_empty) begin
                fault_next = 1'b1;
            end else begin
                pc_next    = stack_mem[pop_idx];
                depth_next = depth_m1;
            end
        end else if (call) begin
            if (stack_full) begin
                fault_next = 1'b1;
            end else begin
                push       = 1'b1;
                pc_next    = bus_in;
                depth_next = depth + ONE_DEPTH;
            end
        end else if (jump) begin
            pc_next = bus_in;
        end else if (branch) begin
            // Same-width add is the sign-extended add modulo 2^W.
            pc_next = pc + bus_in;
        end else if (enable) begin
            pc_next = pc_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_VECTOR;
            depth <= '0;
            fault <= 1'b0;
        end else begin
            pc    <= pc_next;
            depth <= depth_next;
            fault <= fault_next;
        end
    end

    // Entries are not reset; nothing above depth is ever read.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pcounter_stack.sv
// Directed testbench for pcounter_stack (W=4, DEPTH=2, RESET_VECTOR=3).
// Ports of the DUT are all driven/observed; results summarised at the end.
module tb_pcounter_stack;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable, jump, branch, call, ret, out_enable;
    logic [3:0] bus_in;
    logic [3:0] bus_out, pc;
    logic [1:0] depth;
    logic       stack_empty, stack_full, fault;

    int n_checks = 0;
    int n_errors = 0;

    pcounter_stack #(
        .ADDRESS_WIDTH(4),
        .STACK_DEPTH  (2),
        .RESET_VECTOR (4'd3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .jump       (jump),
        .branch     (branch),
        .call       (call),
        .ret        (ret),
        .out_enable (out_enable),
        .bus_in     (bus_in),
        .bus_out    (bus_out),
        .pc         (pc),
        .depth      (depth),
        .stack_empty(stack_empty),
        .stack_full (stack_full),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one command for one edge; strobes cleared right after.
    task automatic cmd(input logic r, input logic c, input logic j,
                       input logic b, input logic e, input logic [3:0] bi);
        @(negedge clk);
        ret = r; call = c; jump = j; branch = b; enable = e; bus_in = bi;
        @(posedge clk);
        #1;
        ret = 0; call = 0; jump = 0; branch = 0; enable = 0;
    endtask

    initial begin
        rst = 1; enable = 0; jump = 0; branch = 0; call = 0; ret = 0;
        out_enable = 0; bus_in = 0;
        #2;
        check("rst_pc", pc, 3);
        check("rst_depth", depth, 0);
        check("rst_empty", stack_empty, 1);
        check("rst_full", stack_full, 0);
        check("rst_fault", fault, 0);
        check("rst_bus", bus_out, 0);
        @(negedge clk);
        rst = 0;

        cmd(0, 0, 1, 0, 0, 4'd14);
        check("jump14", pc, 14);
        cmd(0, 0, 0, 0, 1, 4'd0);
        check("inc15", pc, 15);
        cmd(0, 0, 0, 0, 1, 4'd0);
        check("wrap0", pc, 0);
        cmd(0, 0, 0, 1, 0, 4'b1110);
        check("br_neg", pc, 14);
        cmd(0, 0, 0, 1, 0, 4'b0011);
        check("br_pos", pc, 1);
        cmd(0, 0, 0, 1, 0, 4'b0000);
        check("br_zero", pc, 1);
        cmd(0, 0, 0, 0, 0, 4'd9);
        check("idle", pc, 1);

        cmd(0, 0, 1, 0, 0, 4'd5);
        cmd(0, 1, 0, 0, 0, 4'd9);
        check("call1_pc", pc, 9);
        check("call1_d", depth, 1);
        cmd(0, 1, 0, 0, 0, 4'd12);
        check("call2_pc", pc, 12);
        check("call2_d", depth, 2);
        check("call2_full", stack_full, 1);
        cmd(1, 0, 0, 0, 0, 4'd0);
        check("ret1_pc", pc, 10);
        check("ret1_d", depth, 1);
        cmd(1, 0, 0, 0, 0, 4'd0);
        check("ret2_pc", pc, 6);
        check("ret2_empty", stack_empty, 1);
        check("nofault", fault, 0);

        cmd(0, 1, 0, 0, 0, 4'd9);
        cmd(0, 1, 0, 0, 0, 4'd12);
        cmd(0, 1, 0, 0, 0, 4'd0);
        check("ovf_pc", pc, 12);
        check("ovf_d", depth, 2);
        check("ovf_fault", fault, 1);
        cmd(1, 0, 0, 0, 0, 4'd0);
        check("ret_a", pc, 10);
        cmd(1, 0, 0, 0, 0, 4'd0);
        check("ret_b", pc, 7);
        cmd(1, 0, 0, 0, 0, 4'd0);
        check("unf_pc", pc, 7);
        check("unf_d", depth, 0);
        check("unf_fault", fault, 1);
        cmd(0, 0, 0, 0, 1, 4'd0);
        check("inc_in_fault", pc, 8);
        check("fault_sticky", fault, 1);

        cmd(0, 1, 0, 0, 0, 4'd2);
        #2;
        rst = 1;
        #1;
        check("arst_pc", pc, 3);
        check("arst_d", depth, 0);
        check("arst_empty", stack_empty, 1);
        check("arst_fault", fault, 0);
        out_enable = 1;
        #1;
        check("arst_bus", bus_out, 3);
        cmd(0, 1, 0, 0, 1, 4'd9);
        check("rst_hold_pc", pc, 3);
        check("rst_hold_d", depth, 0);
        @(negedge clk);
        rst = 0;
        out_enable = 0;

        cmd(0, 0, 1, 0, 0, 4'd5);
        cmd(0, 1, 0, 0, 0, 4'd9);
        cmd(1, 1, 0, 0, 1, 4'd4);
        check("prio_ret_pc", pc, 6);
        check("prio_ret_d", depth, 0);
        cmd(0, 0, 1, 1, 1, 4'd2);
        check("prio_jump", pc, 2);

        cmd(0, 0, 1, 0, 0, 4'd15);
        cmd(0, 1, 0, 0, 0, 4'd4);
        check("call15_pc", pc, 4);
        cmd(1, 0, 0, 0, 0, 4'd0);
        check("ret_wrap", pc, 0);

        cmd(0, 0, 1, 0, 0, 4'd11);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            out_enable = (i % 2 == 0);
            #1;
            check("oe_bus", bus_out, (i % 2 == 0) ? 11 : 0);
            check("oe_pc", pc, 11);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pcounter_stack.md
# pcounter_stack

Parametrised program counter with a hardware return-address stack for the CPU control path. Holds the current instruction address, supports increment, absolute jump, PC-relative branch, subroutine call and return, and drives the shared bus when enabled. Replaces the plain counter in designs that need subroutines and wider address spaces; sits between the control sequencer (command strobes) and the shared data bus.

## Interface
- ADDRESS_WIDTH, 4, width of PC, bus_in, bus_out and stack entries (≥2).
- STACK_DEPTH, 4, number of return-address entries (≥1).
- RESET_VECTOR, 0, PC value loaded on reset (ADDRESS_WIDTH bits).
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  increment PC by 1.
- jump  input  1  load PC from bus_in.
- branch  input  1  add bus_in, interpreted as two's-complement signed, to PC.
- call  input  1  push PC+1, load PC from bus_in.
- ret  input  1  pop top of stack into PC.
- out_enable  input  1  drive PC onto bus_out.
- bus_in  input  ADDRESS_WIDTH  target address / signed offset.
- bus_out  output  ADDRESS_WIDTH  PC when out_enable=1, else 0 (combinational).
- pc  output  ADDRESS_WIDTH  current PC, always visible.
- depth  output  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- stack_empty  output  1  depth == 0.
- stack_full  output  1  depth == STACK_DEPTH.
- fault  output  1  sticky: a call on full or ret on empty occurred.

## Operation
- One command acts per cycle; fixed priority: ret > call > jump > branch > enable. Lower-priority strobes asserted in the same cycle are ignored entirely.
- No strobe asserted: PC, stack, depth hold.
- enable: PC <= PC+1, modulo 2^ADDRESS_WIDTH (max value wraps to 0).
- jump: PC <= bus_in.
- branch: PC <= PC + sign-extended bus_in, modulo 2^ADDRESS_WIDTH; offset 0 holds PC; negative offsets wrap below 0.
- call, not full: stack[depth] <= PC+1 (mod 2^W), depth <= depth+1, PC <= bus_in.
- call, full: no push, PC unchanged, depth unchanged, fault <= 1.
- ret, not empty: PC <= stack[depth-1], depth <= depth-1.
- ret, empty: PC unchanged, fault <= 1.
- fault clears only on rst; further commands still execute normally while fault=1.
- Stack is strict LIFO; entries above depth are don't-care and never observable.
- Status outputs (stack_empty, stack_full, depth, pc) are registered-state derived, no combinational path from strobes.

## Timing
- rst asserted: immediately (no clock needed) PC=RESET_VECTOR, depth=0, stack_empty=1, stack_full=0, fault=0; bus_out = out_enable ? RESET_VECTOR : 0. Held while rst=1; strobes ignored.
- rst deasserted: first command sampled on next rising edge.
- Reset mid-operation (e.g. during a call cycle) discards the command; stack contents lost.
- Command latency: strobe sampled at edge N, new PC/depth/fault visible after edge N; bus_out follows pc with zero added latency.
- out_enable is purely combinational onto bus_out; does not affect state.
- Back-to-back call/ret on consecutive cycles supported at full rate; ret immediately after call returns the pushed PC+1.

## Test plan
- W=4, DEPTH=2, RESET_VECTOR=3: assert rst asynchronously between edges -> pc=3, depth=0, stack_empty=1, fault=0 without a clock edge; out_enable=0 -> bus_out=0.
- From pc=14: enable two cycles -> pc=15 then 0; branch with bus_in=4'b1110 (-2) -> pc=14; branch bus_in=4'b0011 from 14 -> pc=1.
- From pc=5: call bus_in=9 -> pc=9, depth=1; call bus_in=12 -> pc=12, depth=2, stack_full=1; ret -> pc=10; ret -> pc=6, stack_empty=1.
- Full stack (depth=2, pc=12): call bus_in=0 -> pc=12, depth=2, fault=1; ret on empty later -> pc unchanged, fault stays 1 until rst.
- Simultaneous ret+call+enable with depth=1 top=6, pc=9 -> pc=6, depth=0 (ret wins); jump+branch+enable with bus_in=2 -> pc=2.
- Call at pc=15 with bus_in=4 -> pushed value 0; ret -> pc=0; out_enable toggling each cycle -> bus_out alternates pc and 0 with no state change.
